// File: rtl/fetch_stage_pkg.sv
// Shared types and widths for the instruction fetch stage.
package fetch_stage_pkg;

    localparam int unsigned PC_W    = 8;
    localparam int unsigned INSTR_W = 32;
    localparam int unsigned CNT_W   = 16;

    localparam logic [INSTR_W-1:0] NOP = '0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_STALL = 2'd2
    } state_e;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction memory bus between the fetch stage and the memory.
interface fetch_stage_if;
    import fetch_stage_pkg::*;

    logic               imem_read;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_data;

    modport master (output imem_read, output imem_addr, input imem_data);
    modport slave  (input imem_read, input imem_addr, output imem_data);

endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: squash beats hold, hold beats load.
module if_id_reg
    import fetch_stage_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               hold_i,
    input  logic               squash_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic [PC_W-1:0]    pc_i,
    output logic [INSTR_W-1:0] instr_o,
    output logic [PC_W-1:0]    pc_o,
    output logic               valid_o
);

    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic               valid_q, valid_d;

    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        if (squash_i) begin
            // Bubble keeps the previous pc; only the instruction and valid are killed.
            instr_d = NOP;
            valid_d = 1'b0;
        end else if (!hold_i) begin
            instr_d = instr_i;
            pc_d    = pc_i;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q <= NOP;
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    assign instr_o = instr_q;
    assign pc_o    = pc_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, IDLE/FETCH/STALL control, fetch counter and IF/ID register.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [PC_W-1:0] PC_RESET = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 redirect,
    input  logic [PC_W-1:0]      redirect_target,
    fetch_stage_if.master        imem,
    output logic [INSTR_W-1:0]   if_id_instr,
    output logic [PC_W-1:0]      if_id_pc,
    output logic                 if_id_valid,
    output logic [CNT_W-1:0]     fetch_count
);

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              imem_read_c;
    logic              do_fetch_c;
    logic              do_redirect_c;

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  state_d = ST_FETCH;
            ST_FETCH: if (stall && !redirect) state_d = ST_STALL;
            ST_STALL: if (!stall || redirect) state_d = ST_FETCH;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Redirect outranks stall; leaving STALL on a stall drop costs one idle cycle.
    always_comb begin
        imem_read_c   = 1'b0;
        do_fetch_c    = 1'b0;
        do_redirect_c = 1'b0;
        unique case (state_q)
            ST_FETCH: begin
                imem_read_c = 1'b1;
                if (redirect)    do_redirect_c = 1'b1;
                else if (!stall) do_fetch_c    = 1'b1;
            end
            ST_STALL: begin
                imem_read_c = 1'b1;
                if (redirect) do_redirect_c = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        pc_d  = pc_q;
        cnt_d = cnt_q;
        if (do_redirect_c)   pc_d = redirect_target;
        else if (do_fetch_c) pc_d = pc_q + PC_W'(1);
        if (do_fetch_c && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q  <= PC_RESET;
            cnt_q <= '0;
        end else begin
            pc_q  <= pc_d;
            cnt_q <= cnt_d;
        end
    end

    if_id_reg u_if_id_reg (
        .clk      (clk),
        .rst      (rst),
        .hold_i   (!do_fetch_c),
        .squash_i (do_redirect_c),
        .instr_i  (imem.imem_data),
        .pc_i     (pc_q),
        .instr_o  (if_id_instr),
        .pc_o     (if_id_pc),
        .valid_o  (if_id_valid)
    );

    assign imem.imem_read = imem_read_c;
    assign imem.imem_addr = pc_q;
    assign fetch_count    = cnt_q;

endmodule
